bram_seg_pipe: RTL

//  Parametrised successor to the plain simple-dual-port buffer. Adds per-segment write enables,
//  a selectable read latency (1 or 2) with rd_vld, and a defined read-during-write collision mode.

---
 rtl/bram_seg_pipe_pkg.sv | 18 +
 rtl/bram_seg_core.sv | 32 +++
 rtl/bram_seg_pipe.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bram_seg_pipe_pkg.sv
// Shared definitions for the segmented, pipelined block-RAM buffer that sits
// between the DMA loader and the PC node compute array.
package bram_seg_pipe_pkg;

    localparam int BRAM_ADDR_WIDTH = 11;
    localparam int BRAM_DATA_WIDTH = 192;
    localparam int BRAM_DEPTH      = 2048;

    localparam int COLLISION_READ_FIRST  = 0;
    localparam int COLLISION_WRITE_FIRST = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clearState_e;

endpackage

// File: rtl/bram_seg_core.sv
// One write-enable segment of the buffer: a simple dual-port RAM with a
// registered read port. The read register returns the pre-write word when
// both ports hit the same address on the same edge.
module bram_seg_core
    import bram_seg_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int SEG_WIDTH  = 16,
    parameter int DEPTH      = BRAM_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] rdAddr_i,
    output logic [SEG_WIDTH-1:0]  rdData_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] wrAddr_i,
    input  logic [SEG_WIDTH-1:0]  wrData_i
);

    (* ram_style = "block" *) logic [SEG_WIDTH-1:0] memArray [0:DEPTH-1];

    // Storage array and its output register; neither is reset so the tools map it onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memArray[wrAddr_i] <= wrData_i;
        end
        if (re_i) begin
            rdData_o <= memArray[rdAddr_i];
        end
    end

endmodule

// File: rtl/bram_seg_pipe.sv
// Segmented simple-dual-port buffer with selectable read latency, defined
// read-during-write behaviour and a hardware zero-fill engine. The top owns the
// collision forwarding, output pipeline, clear FSM and the RAM write mux.
module bram_seg_pipe
    import bram_seg_pipe_pkg::*;
#(
    parameter int ADDR_WIDTH     = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH     = BRAM_DATA_WIDTH,
    parameter int DEPTH          = BRAM_DEPTH,
    parameter int SEG_WIDTH      = 16,
    parameter int RD_LATENCY     = 1,
    parameter int COLLISION_MODE = COLLISION_READ_FIRST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic                             rd_vld,
    input  logic                             we,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [DATA_WIDTH/SEG_WIDTH-1:0]  wr_seg_en,
    input  logic                             init_start,
    output logic                             init_busy,
    output logic                             init_done
);

    localparam int NUM_SEGS = DATA_WIDTH / SEG_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W     = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam bit                    WRITE_FIRST = (COLLISION_MODE == COLLISION_WRITE_FIRST);

    if ((DATA_WIDTH % SEG_WIDTH) != 0) begin : gen_err_seg
        $error("bram_seg_pipe: DATA_WIDTH must be a multiple of SEG_WIDTH");
    end
    if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : gen_err_lat
        $error("bram_seg_pipe: RD_LATENCY must be 1 or 2");
    end
    if ((COLLISION_MODE != COLLISION_READ_FIRST) && (COLLISION_MODE != COLLISION_WRITE_FIRST)) begin : gen_err_col
        $error("bram_seg_pipe: COLLISION_MODE must be 0 or 1");
    end
    if (DEPTH > (2 ** ADDR_WIDTH)) begin : gen_err_depth
        $error("bram_seg_pipe: DEPTH does not fit in ADDR_WIDTH");
    end

    clearState_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clrCnt_q, clrCnt_d;

    logic                    busy;
    logic                    rdInRange, wrInRange;
    logic                    extRe, extWe, coreRe, collide;

    logic [NUM_SEGS-1:0]     memWe;
    logic [ADDR_WIDTH-1:0]   memWrAddr;
    logic [DATA_WIDTH-1:0]   memWrData;
    logic [DATA_WIDTH-1:0]   coreRdData;

    logic                    vld1_q;
    logic                    hit1_q;
    logic [NUM_SEGS-1:0]     fwdMask1_q;
    logic [DATA_WIDTH-1:0]   fwdData1_q;
    logic [DATA_WIDTH-1:0]   stage1Data;

    // While the clear engine owns the RAM, external requests are dropped entirely.
    assign busy      = (state_q != ST_IDLE);
    assign rdInRange = ({1'b0, rd_addr} < DEPTH_W);
    assign wrInRange = ({1'b0, wr_addr} < DEPTH_W);
    assign extRe     = re & ~busy;
    assign extWe     = we & ~busy & wrInRange;
    assign coreRe    = extRe & rdInRange;
    assign collide   = coreRe & extWe & (rd_addr == wr_addr);

    assign init_busy = busy;
    assign init_done = (state_q == ST_DONE);

    // Clear FSM state and address counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            clrCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            clrCnt_q <= clrCnt_d;
        end
    end

    // Clear sequencing: sweep 0..DEPTH-1 once, stop at the last address without wrapping.
    always_comb begin
        state_d  = state_q;
        clrCnt_d = clrCnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d  = ST_CLEAR;
                    clrCnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clrCnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    clrCnt_d = clrCnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM write port: zero words from the clear engine, otherwise the gated external write.
    always_comb begin
        memWe     = '0;
        memWrAddr = wr_addr;
        memWrData = wr_data;
        if (state_q == ST_CLEAR) begin
            memWe     = '1;
            memWrAddr = clrCnt_q;
            memWrData = '0;
        end else if (extWe) begin
            memWe = wr_seg_en;
        end
    end

    for (genvar s = 0; s < NUM_SEGS; s++) begin : gen_seg
        bram_seg_core #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .SEG_WIDTH  (SEG_WIDTH),
            .DEPTH      (DEPTH)
        ) u_core (
            .clk_i    (clk),
            .re_i     (coreRe),
            .rdAddr_i (rd_addr),
            .rdData_o (coreRdData[s*SEG_WIDTH +: SEG_WIDTH]),
            .we_i     (memWe[s]),
            .wrAddr_i (memWrAddr),
            .wrData_i (memWrData[s*SEG_WIDTH +: SEG_WIDTH])
        );
    end

    // First read stage side-band: valid, in-range hit and the write-first forwarding captured alongside the RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q     <= 1'b0;
            hit1_q     <= 1'b0;
            fwdMask1_q <= '0;
            fwdData1_q <= '0;
        end else begin
            vld1_q     <= extRe;
            hit1_q     <= coreRe;
            fwdMask1_q <= (WRITE_FIRST && collide) ? wr_seg_en : '0;
            if (WRITE_FIRST && collide) begin
                fwdData1_q <= wr_data;
            end
        end
    end

    // Merge forwarded segments over the RAM word; empty or out-of-range slots read as zero.
    always_comb begin
        stage1Data = '0;
        if (hit1_q) begin
            for (int s = 0; s < NUM_SEGS; s++) begin
                stage1Data[s*SEG_WIDTH +: SEG_WIDTH] = fwdMask1_q[s] ? fwdData1_q[s*SEG_WIDTH +: SEG_WIDTH]
                                                                     : coreRdData[s*SEG_WIDTH +: SEG_WIDTH];
            end
        end
    end

    if (RD_LATENCY == 2) begin : gen_lat2
        logic                  vld2_q;
        logic [DATA_WIDTH-1:0] data2_q;

        // Extra output register; the zeroed data of empty slots travels through it unchanged.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld2_q  <= 1'b0;
                data2_q <= '0;
            end else begin
                vld2_q  <= vld1_q;
                data2_q <= stage1Data;
            end
        end

        assign rd_vld  = vld2_q;
        assign rd_data = data2_q;
    end else begin : gen_lat1
        assign rd_vld  = vld1_q;
        assign rd_data = stage1Data;
    end

endmodule
